// File: rtl/csa_seq_accumulator_if.sv
// Operand/result handshake bundle for csa_seq_accumulator.
// master drives beats and result-ready; slave is the accumulator.
interface csa_seq_accumulator_if #(
  parameter int K = 16,
  parameter int W = 20
);
  logic         in_valid;
  logic         in_ready;
  logic [K-1:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_overflow;
  logic         busy;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_overflow, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_overflow, busy
  );
endinterface

// File: rtl/csa_seq_accumulator.sv
// Carry-save multi-operand accumulator with guard bits and a
// chunked carry-propagate resolve before the result handshake.
module csa_seq_accumulator #(
  parameter int K      = 16,
  parameter int GUARD  = 4,
  parameter int CHUNK  = 8,
  parameter int SIGNED = 0
) (
  input logic             clk,
  input logic             rst,
  csa_seq_accumulator_if.slave bus
);
  localparam int W   = K + GUARD;
  localparam int NCH = (W + CHUNK - 1) / CHUNK;
  localparam int PW  = NCH * CHUNK;
  localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW  = GUARD + 2;

  localparam logic [CW-1:0] LIM  = CW'(2 ** GUARD);
  localparam logic [CW-1:0] SAT  = CW'(2 ** GUARD + 1);
  localparam logic [IW-1:0] LAST = IW'(NCH - 1);
  localparam logic [PW-1:0] CMASK = PW'({CHUNK{1'b1}});

  typedef enum logic [1:0] {
    ST_ACC,
    ST_RES,
    ST_OUT
  } state_e;

  state_e        state_q, state_d;
  logic [W-1:0]  s_q, s_d;
  logic [W-1:0]  c_q, c_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          rc_q, rc_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  res_q, res_d;

  logic [W-1:0]   ext;
  logic [CHUNK-1:0] s_ch;
  logic [CHUNK-1:0] c_ch;
  logic [CHUNK:0]   csum;
  logic           acc_st;
  logic           accept;
  int             sh;

  assign acc_st = (state_q == ST_ACC);
  assign accept = bus.in_valid && acc_st;

  assign ext = (SIGNED != 0) ? W'($signed(bus.in_data))
                             : W'(bus.in_data);

  // Upper pad bits of the last chunk read as zero.
  always_comb begin
    sh   = int'(idx_q) * CHUNK;
    s_ch = CHUNK'(PW'(s_q) >> sh);
    c_ch = CHUNK'(PW'(c_q) >> sh);
    csum = {1'b0, s_ch} + {1'b0, c_ch}
         + {{CHUNK{1'b0}}, rc_q};
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rc_d    = rc_q;
    idx_d   = idx_q;
    res_d   = res_q;
    unique case (state_q)
      ST_ACC: begin
        if (accept) begin
          s_d = s_q ^ c_q ^ ext;
          c_d = ((s_q & c_q) | (s_q & ext)
              | (c_q & ext)) << 1;
          cnt_d = (cnt_q == SAT) ? cnt_q
                                 : cnt_q + CW'(1);
          if (cnt_q >= LIM) ovf_d = 1'b1;
          if (bus.in_last) begin
            state_d = ST_RES;
            idx_d   = '0;
            rc_d    = 1'b0;
          end
        end
      end
      ST_RES: begin
        res_d = W'((PW'(res_q) & ~(CMASK << sh))
              | (PW'(csum[CHUNK-1:0]) << sh));
        rc_d  = csum[CHUNK];
        if (idx_q == LAST) state_d = ST_OUT;
        else idx_d = idx_q + IW'(1);
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d = ST_ACC;
          s_d     = '0;
          c_d     = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ST_ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ACC;
      s_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rc_q    <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rc_q    <= rc_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
    end
  end

  assign bus.in_ready     = acc_st;
  assign bus.out_valid    = (state_q == ST_OUT);
  assign bus.out_data     = res_q;
  assign bus.out_overflow = ovf_q && (state_q == ST_OUT);
  assign bus.busy         = (cnt_q != '0) || !acc_st;
endmodule

// File: tb/tb_csa_seq_accumulator.sv
// Bench for csa_seq_accumulator: eight chunk/sign configs share
// one stimulus stream; per-config scoreboards check each result.
module tb_csa_seq_accumulator;
  localparam int K  = 8;
  localparam int G  = 4;
  localparam int W  = 12;
  localparam int NI = 8;

  function automatic int ch_of(input int i);
    case (i)
      0, 1:    return 4;
      2, 3:    return 1;
      4, 5:    return 5;
      default: return 12;
    endcase
  endfunction

  function automatic int sg_of(input int i);
    return i % 2;
  endfunction

  typedef struct packed {
    logic [W-1:0] data;
    logic         ovf;
  } exp_t;

  exp_t sb_q [NI][$];

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic out_ready = 1'b1;
  logic [K-1:0] in_data = '0;

  logic [NI-1:0] rdy, ov, bsy, ovf;
  logic [W-1:0]  od [NI];

  logic [W-1:0] acc_u = '0;
  logic [W-1:0] acc_s = '0;
  int nb = 0;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g
    csa_seq_accumulator_if #(.K(K), .W(W)) io ();
    assign io.in_valid  = in_valid;
    assign io.in_data   = in_data;
    assign io.in_last   = in_last;
    assign io.out_ready = out_ready;
    assign rdy[gi] = io.in_ready;
    assign ov[gi]  = io.out_valid;
    assign bsy[gi] = io.busy;
    assign ovf[gi] = io.out_overflow;
    assign od[gi]  = io.out_data;

    csa_seq_accumulator #(
      .K(K), .GUARD(G),
      .CHUNK(ch_of(gi)), .SIGNED(sg_of(gi))
    ) u_dut (
      .clk(clk),
      .rst(rst),
      .bus(io)
    );

    initial begin
      forever begin
        @(negedge clk);
        if (!rst && io.out_valid && out_ready) begin
          exp_t e;
          if (sb_q[gi].size() == 0) begin
            chk($sformatf("spurious_out%0d", gi), 1, 0);
          end else begin
            e = sb_q[gi].pop_front();
            chk($sformatf("data%0d", gi),
                io.out_data, e.data);
            chk($sformatf("ovf%0d", gi),
                io.out_overflow, e.ovf);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      in_data = K'($urandom);
      in_last = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic beat(input logic [K-1:0] d,
                      input logic last);
    exp_t e;
    chk("rdy_at_beat", rdy, {NI{1'b1}});
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(posedge clk); #1;
    acc_u = acc_u + {4'b0, d};
    acc_s = acc_s + {{4{d[7]}}, d};
    nb++;
    in_valid = 1'b0;
    in_data  = K'($urandom);
    in_last  = 1'($urandom);
    if (last) begin
      for (int k = 0; k < NI; k++) begin
        e.data = (sg_of(k) != 0) ? acc_s : acc_u;
        e.ovf  = (nb > 16);
        sb_q[k].push_back(e);
      end
      acc_u = '0;
      acc_s = '0;
      nb = 0;
    end
  endtask

  task automatic wait_idle(input logic rnd);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 2000 && !done; c++) begin
      if (bsy == '0) done = 1'b1;
      else begin
        out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        @(posedge clk); #1;
      end
    end
    if (!done) chk("idle_timeout", 0, 1);
    out_ready = 1'b1;
  endtask

  task automatic wait_v(input int i);
    bit hit;
    hit = 1'b0;
    for (int c = 0; c < 100 && !hit; c++) begin
      if (ov[i]) hit = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    chk("wait_valid", ov[i], 1);
  endtask

  initial begin
    int len;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", rdy, {NI{1'b1}});
    chk("rst_out_valid", ov, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", bsy, 0);
    chk("rst_data0", od[0], 0);
    rst = 1'b0;
    idle(2);

    beat(8'd255, 1'b0);
    beat(8'd255, 1'b0);
    beat(8'd255, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk("t1_lat_low", ov[0], 0);
    end
    @(negedge clk);
    chk("t1_lat_high", ov[0], 1);
    chk("t1_data", od[0], 12'h2FD);
    chk("t1_ovf", ovf[0], 0);
    wait_idle(1'b0);

    out_ready = 1'b0;
    for (int i = 0; i < 17; i++) beat(8'd255, i == 16);
    wait_v(0);
    chk("t2_17_data", od[0], 12'h0EF);
    chk("t2_17_ovf", ovf[0], 1);
    wait_idle(1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) beat(8'd255, i == 15);
    wait_v(0);
    chk("t2_16_data", od[0], 12'hFF0);
    chk("t2_16_ovf", ovf[0], 0);
    wait_idle(1'b1);

    out_ready = 1'b0;
    beat(8'hFF, 1'b0);
    beat(8'hFE, 1'b0);
    beat(8'h03, 1'b1);
    wait_v(1);
    chk("t3a_signed", od[1], 12'h000);
    chk("t3a_unsigned", od[0], 12'h200);
    wait_idle(1'b1);
    out_ready = 1'b0;
    beat(8'h80, 1'b0);
    beat(8'h80, 1'b1);
    wait_v(1);
    chk("t3b_signed", od[1], 12'hF00);
    chk("t3b_unsigned", od[0], 12'h100);
    wait_idle(1'b1);

    out_ready = 1'b0;
    beat(8'd10, 1'b0);
    beat(8'd20, 1'b0);
    beat(8'd30, 1'b1);
    wait_v(0);
    repeat (5) begin
      @(negedge clk);
      chk("t4_hold_valid", ov[0], 1);
      chk("t4_hold_data", od[0], 12'h03C);
      chk("t4_hold_rdy", rdy[0], 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("t4_rel_valid", ov[0], 0);
    chk("t4_rel_rdy", rdy[0], 1);
    wait_idle(1'b1);

    beat(8'd100, 1'b0);
    beat(8'd100, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    acc_u = '0;
    acc_s = '0;
    nb = 0;
    chk("t5_mid_busy", bsy, 0);
    chk("t5_mid_valid", ov, 0);
    out_ready = 1'b0;
    beat(8'd5, 1'b1);
    wait_v(0);
    chk("t5_data", od[0], 12'h005);
    chk("t5_ovf", ovf[0], 0);
    wait_idle(1'b1);

    beat(8'd1, 1'b0);
    beat(8'd2, 1'b0);
    beat(8'd3, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < NI; k++) sb_q[k].delete();
    chk("t5_res_valid", ov, 0);
    chk("t5_res_rdy", rdy, {NI{1'b1}});
    chk("t5_res_busy", bsy, 0);
    chk("t5_res_ovf", ovf, 0);
    chk("t5_res_data0", od[0], 0);
    chk("t5_res_data6", od[6], 0);
    idle(20);

    for (int p = 0; p < 30; p++) begin
      len = $urandom_range(1, 40);
      for (int b = 0; b < len; b++) begin
        if ($urandom_range(0, 2) == 0)
          idle($urandom_range(1, 3));
        beat(K'($urandom), b == len - 1);
      end
      wait_idle(1'b1);
    end

    idle(4);
    for (int k = 0; k < NI; k++)
      chk($sformatf("sb_empty%0d", k), sb_q[k].size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end
endmodule
